// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Control FSM for a multicycle MIPS datapath. It steps each instruction
//   through FETCH/DECODE/EXECUTE/MEM/WB, drives the datapath mux selects and
//   write enables, performs the memory handshake, and decodes the ALU
//   function from Opcode/Funct.
// Parameters
//   USE_MEM_READY  1: FETCH/MEMRD/MEMWR wait for MemReady; 0: memory always ready
//   CNT_W          width of the retired-instruction counter
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   Opcode, Funct         instruction fields (IR[31:26], IR[5:0])
//   Zero                  ALU zero flag, used in BRANCH for PCEn
//   MemReady              memory finishes the current access this cycle
//   IorD, MemWrite        memory address select and write strobe
//   IRWrite               instruction register load
//   RegDst, MemtoReg      register file write address / data selects
//   RegWrite              register file write enable
//   ALUSrcA, ALUSrcB      ALU operand selects
//   ALUControl            010 add, 110 sub, 000 and, 001 or, 111 slt
//   PCSrc, PCEn           next-PC select and PC load enable
//   IllegalOp             sticky flag: unsupported Opcode/Funct decoded
//   InstrCount            retired-instruction count (wraps)
module mips_multicycle_control #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, ADDIEXEC, ADDIWB, BRANCH, JUMP
  } state_t;

  state_t           state_reg, state_next;
  logic             illegal_reg;
  logic [CNT_W-1:0] count_reg;
  logic             mem_ready;
  logic             illegal_set;
  logic             retire;
  logic             funct_ok;
  logic [2:0]       funct_alu;

  assign mem_ready  = USE_MEM_READY ? MemReady : 1'b1;
  assign IllegalOp  = illegal_reg;
  assign InstrCount = count_reg;

  // R-type function decode; funct_ok flags the supported subset.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (Funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (illegal_set) illegal_reg <= 1'b1;
      if (retire)      count_reg   <= count_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next  = state_reg;
    illegal_set = 1'b0;
    retire      = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = 3'b010;
    PCSrc       = 2'b00;
    PCEn        = 1'b0;
    case (state_reg)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // Branch target is computed here so BRANCH can take it from ALUOut.
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXEC;
          OP_J:         state_next = JUMP;
          OP_R: begin
            if (funct_ok) state_next = EXECUTE;
            else begin
              illegal_set = 1'b1;
              state_next  = FETCH;
            end
          end
          default: begin
            illegal_set = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        PCEn       = Zero;
        retire     = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        PCEn       = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    // Enables must be quiet for the whole reset pulse, including the cycle
    // the state register is forced back to FETCH (whose IRWrite/PCEn follow
    // MemReady).
    if (reset) begin
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      PCEn     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode, Funct;
  logic        Zero, MemReady;
  logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUControl;
  logic        PCEn, IllegalOp;
  logic [31:0] InstrCount;

  mips_multicycle_control #(.USE_MEM_READY(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn),
    .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic       pcen;
  } snap_t;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
  } exp_t;

  snap_t       tr [0:31];     // outputs per cycle, index 0 = FETCH cycle with MemReady=1
  logic        stall_irwrite;
  exp_t        sb_q [$];
  logic [31:0] exp_count = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic snap_t snap();
    return '{IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, ALUControl, PCSrc, PCEn};
  endfunction

  // Runs one instruction starting at a negedge in FETCH; returns the cycle
  // count from the FETCH MemReady cycle until the FSM is back in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, output int cyc);
    int left;
    Opcode = op; Funct = fn; Zero = z; left = mw;
    stall_irwrite = 1'b0;
    for (int i = 0; i < fw; i++) begin
      MemReady = 1'b0;
      #1 stall_irwrite = stall_irwrite | IRWrite | PCEn;
      @(negedge clk);
    end
    MemReady = 1'b1;
    #1 tr[0] = snap();
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (IorD && left > 0) begin MemReady = 1'b0; left--; end
      else MemReady = 1'b1;
      #1;
      if (ALUSrcB == 2'b01 || cyc >= 30) break;
      tr[cyc] = snap();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; MemReady = 1'b1; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (IRWrite !== 1'b0)    begin n_miss++; $display("FAIL reset_irwrite got %b want 0", IRWrite); end
    n_vec++; if (PCEn !== 1'b0)       begin n_miss++; $display("FAIL reset_pcen got %b want 0", PCEn); end
    n_vec++; if (MemWrite !== 1'b0)   begin n_miss++; $display("FAIL reset_memwrite got %b want 0", MemWrite); end
    n_vec++; if (RegWrite !== 1'b0)   begin n_miss++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
    n_vec++; if (InstrCount !== 32'd0) begin n_miss++; $display("FAIL reset_count got %0d want 0", InstrCount); end
    n_vec++; if (IllegalOp !== 1'b0)  begin n_miss++; $display("FAIL reset_illegal got %b want 0", IllegalOp); end
    n_vec++; if (ALUSrcB !== 2'b01)   begin n_miss++; $display("FAIL reset_srcb got %b want 01", ALUSrcB); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (IRWrite !== 1'b1)    begin n_miss++; $display("FAIL post_reset_fetch_irwrite got %b want 1", IRWrite); end
    $display("reset: released, FETCH with IRWrite=%b", IRWrite);
  endtask

  task automatic test_lw();
    int   cyc;
    exp_t e;
    exp_count++;
    sb_q.push_back('{7, exp_count});
    run_instr(6'b100011, 6'd0, 1'b0, 2, 2, cyc);
    e = sb_q.pop_front();
    $display("lw: %0d cycles, count %0d", cyc, InstrCount);
    n_vec++; if (cyc !== e.cyc)          begin n_miss++; $display("FAIL lw_latency got %0d want %0d", cyc, e.cyc); end
    n_vec++; if (InstrCount !== e.cnt)   begin n_miss++; $display("FAIL lw_count got %0d want %0d", InstrCount, e.cnt); end
    n_vec++; if (stall_irwrite !== 1'b0) begin n_miss++; $display("FAIL lw_fetch_stall_enable got %b want 0", stall_irwrite); end
    n_vec++; if (tr[1].srcb !== 2'b11)   begin n_miss++; $display("FAIL lw_decode_srcb got %b want 11", tr[1].srcb); end
    n_vec++; if ({tr[2].srca, tr[2].srcb} !== 3'b110) begin n_miss++; $display("FAIL lw_memadr_src got %b want 110", {tr[2].srca, tr[2].srcb}); end
    for (int i = 0; i <= 6; i++) begin
      n_vec++;
      if ({tr[i].regwrite, tr[i].memtoreg} !== ((i == 6) ? 2'b11 : 2'b00)) begin
        n_miss++;
        $display("FAIL lw_wb_cycle%0d got %b want %b", i, {tr[i].regwrite, tr[i].memtoreg}, (i == 6) ? 2'b11 : 2'b00);
      end
    end
    n_vec++; if ({tr[4].iord, tr[4].irwrite} !== 2'b10) begin n_miss++; $display("FAIL lw_memrd_wait got %b want 10", {tr[4].iord, tr[4].irwrite}); end
  endtask

  task automatic test_rtype();
    logic [5:0] fns  [0:4];
    logic [2:0] alus [0:4];
    int   cyc;
    exp_t e;
    fns  = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101};
    alus = '{3'b111, 3'b010, 3'b110, 3'b000, 3'b001};
    for (int k = 0; k < 5; k++) begin
      exp_count++;
      sb_q.push_back('{4, exp_count});
      run_instr(6'b000000, fns[k], 1'b0, 0, 0, cyc);
      e = sb_q.pop_front();
      $display("rtype funct=%b: %0d cycles, ALUControl %b, count %0d", fns[k], cyc, tr[2].aluc, InstrCount);
      n_vec++; if (cyc !== e.cyc)        begin n_miss++; $display("FAIL r_latency got %0d want %0d", cyc, e.cyc); end
      n_vec++; if (InstrCount !== e.cnt) begin n_miss++; $display("FAIL r_count got %0d want %0d", InstrCount, e.cnt); end
      n_vec++; if (tr[2].aluc !== alus[k]) begin n_miss++; $display("FAIL r_aluctl got %b want %b", tr[2].aluc, alus[k]); end
      n_vec++; if ({tr[2].srca, tr[2].srcb} !== 3'b100) begin n_miss++; $display("FAIL r_exec_src got %b want 100", {tr[2].srca, tr[2].srcb}); end
      n_vec++; if ({tr[3].regdst, tr[3].regwrite, tr[3].memtoreg} !== 3'b110) begin n_miss++; $display("FAIL r_aluwb got %b want 110", {tr[3].regdst, tr[3].regwrite, tr[3].memtoreg}); end
    end
  endtask

  task automatic test_beq();
    int   cyc;
    exp_t e;
    for (int z = 1; z >= 0; z--) begin
      exp_count++;
      sb_q.push_back('{3, exp_count});
      run_instr(6'b000100, 6'd0, z[0], 0, 0, cyc);
      e = sb_q.pop_front();
      $display("beq zero=%0d: %0d cycles, PCEn %b, count %0d", z, cyc, tr[2].pcen, InstrCount);
      n_vec++; if (cyc !== e.cyc)        begin n_miss++; $display("FAIL beq_latency got %0d want %0d", cyc, e.cyc); end
      n_vec++; if (InstrCount !== e.cnt) begin n_miss++; $display("FAIL beq_count got %0d want %0d", InstrCount, e.cnt); end
      n_vec++; if (tr[2].pcen !== z[0])  begin n_miss++; $display("FAIL beq_pcen got %b want %b", tr[2].pcen, z[0]); end
      n_vec++; if ({tr[2].pcsrc, tr[2].aluc, tr[2].srca, tr[2].srcb} !== 8'b01_110_1_00) begin
        n_miss++; $display("FAIL beq_selects got %b want 01110100", {tr[2].pcsrc, tr[2].aluc, tr[2].srca, tr[2].srcb});
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops  [0:2];
    int         lats [0:2];
    int   cyc;
    exp_t e;
    ops  = '{6'b101011, 6'b001000, 6'b000010};
    lats = '{4, 4, 3};
    for (int k = 0; k < 3; k++) begin
      exp_count++;
      sb_q.push_back('{lats[k], exp_count});
    end
    for (int k = 0; k < 3; k++) begin
      run_instr(ops[k], 6'd0, 1'b0, 0, 0, cyc);
      e = sb_q.pop_front();
      $display("b2b op=%b: %0d cycles, count %0d", ops[k], cyc, InstrCount);
      n_vec++; if (cyc !== e.cyc)        begin n_miss++; $display("FAIL b2b_latency op=%b got %0d want %0d", ops[k], cyc, e.cyc); end
      n_vec++; if (InstrCount !== e.cnt) begin n_miss++; $display("FAIL b2b_count op=%b got %0d want %0d", ops[k], InstrCount, e.cnt); end
      if (k == 0) begin
        n_vec++; if ({tr[3].iord, tr[3].memwrite, tr[3].regwrite} !== 3'b110) begin n_miss++; $display("FAIL sw_memwr got %b want 110", {tr[3].iord, tr[3].memwrite, tr[3].regwrite}); end
      end else if (k == 1) begin
        n_vec++; if ({tr[2].srca, tr[2].srcb, tr[2].aluc} !== 6'b110_010) begin n_miss++; $display("FAIL addi_exec got %b want 110010", {tr[2].srca, tr[2].srcb, tr[2].aluc}); end
        n_vec++; if ({tr[3].regdst, tr[3].memtoreg, tr[3].regwrite} !== 3'b001) begin n_miss++; $display("FAIL addi_wb got %b want 001", {tr[3].regdst, tr[3].memtoreg, tr[3].regwrite}); end
      end else begin
        n_vec++; if ({tr[2].pcsrc, tr[2].pcen} !== 3'b101) begin n_miss++; $display("FAIL jump_pc got %b want 101", {tr[2].pcsrc, tr[2].pcen}); end
      end
    end
  endtask

  task automatic test_illegal();
    int   cyc;
    exp_t e;
    sb_q.push_back('{2, exp_count});
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, cyc);
    e = sb_q.pop_front();
    $display("illegal opcode: %0d cycles, IllegalOp %b, count %0d", cyc, IllegalOp, InstrCount);
    n_vec++; if (cyc !== e.cyc)        begin n_miss++; $display("FAIL ill_latency got %0d want %0d", cyc, e.cyc); end
    n_vec++; if (InstrCount !== e.cnt) begin n_miss++; $display("FAIL ill_count got %0d want %0d", InstrCount, e.cnt); end
    n_vec++; if (IllegalOp !== 1'b1)   begin n_miss++; $display("FAIL ill_flag got %b want 1", IllegalOp); end
    sb_q.push_back('{2, exp_count});
    run_instr(6'b000000, 6'b000001, 1'b0, 0, 0, cyc);
    e = sb_q.pop_front();
    $display("illegal funct: %0d cycles, count %0d", cyc, InstrCount);
    n_vec++; if (cyc !== e.cyc)        begin n_miss++; $display("FAIL ill_funct_latency got %0d want %0d", cyc, e.cyc); end
    n_vec++; if (InstrCount !== e.cnt) begin n_miss++; $display("FAIL ill_funct_count got %0d want %0d", InstrCount, e.cnt); end
    exp_count++;
    sb_q.push_back('{4, exp_count});
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0, cyc);
    e = sb_q.pop_front();
    $display("addi after illegal: %0d cycles, IllegalOp %b, count %0d", cyc, IllegalOp, InstrCount);
    n_vec++; if (InstrCount !== e.cnt) begin n_miss++; $display("FAIL ill_then_addi_count got %0d want %0d", InstrCount, e.cnt); end
    n_vec++; if (IllegalOp !== 1'b1)   begin n_miss++; $display("FAIL ill_sticky got %b want 1", IllegalOp); end
  endtask

  task automatic test_reset_midaccess();
    Opcode = 6'b101011; Funct = 6'd0; MemReady = 1'b1;
    repeat (3) @(negedge clk);   // DECODE, MEMADR, MEMWR
    MemReady = 1'b0;
    #1;
    n_vec++; if (MemWrite !== 1'b1) begin n_miss++; $display("FAIL midreset_memwr_active got %b want 1", MemWrite); end
    @(negedge clk);
    #1;
    n_vec++; if (MemWrite !== 1'b1) begin n_miss++; $display("FAIL midreset_memwr_held got %b want 1", MemWrite); end
    #2 reset = 1'b1;
    #1;
    $display("midreset: reset in MEMWR, MemWrite %b", MemWrite);
    n_vec++; if (MemWrite !== 1'b0) begin n_miss++; $display("FAIL midreset_memwrite got %b want 0", MemWrite); end
    n_vec++; if (ALUSrcB !== 2'b01) begin n_miss++; $display("FAIL midreset_fetch_srcb got %b want 01", ALUSrcB); end
    @(negedge clk);
    reset = 1'b0; MemReady = 1'b1;
    exp_count = 0;
    #1;
    n_vec++; if ({IRWrite, PCEn, ALUSrcB} !== 4'b1101) begin n_miss++; $display("FAIL midreset_fetch got %b want 1101", {IRWrite, PCEn, ALUSrcB}); end
    n_vec++; if (InstrCount !== exp_count) begin n_miss++; $display("FAIL midreset_count got %0d want %0d", InstrCount, exp_count); end
    n_vec++; if (IllegalOp !== 1'b0) begin n_miss++; $display("FAIL midreset_illegal got %b want 0", IllegalOp); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_midaccess();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
